// File: rtl/pc_flag_unit_if.sv
// Signal bundle between the decoder/ALU side and pc_flag_unit.
// The master drives decode, ALU results and LUT loading; the slave returns PC, flags and status.
interface pc_flag_unit_if #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 4,
  parameter int CNT_W  = 16
) ();
  logic              start;
  logic              halt_req;
  logic              branch_ne;
  logic              branch_lt;
  logic [LUT_AW-1:0] lut_idx;
  logic              notequal;
  logic              lessthan;
  logic              sc_we;
  logic              sc_o;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   pc;
  logic              sc_in;
  logic              running;
  logic              done;
  logic [CNT_W-1:0]  instr_cnt;

  modport master (
    output start, halt_req, branch_ne, branch_lt, lut_idx,
           notequal, lessthan, sc_we, sc_o,
           lut_we, lut_waddr, lut_wdata,
    input  pc, sc_in, running, done, instr_cnt
  );

  modport slave (
    input  start, halt_req, branch_ne, branch_lt, lut_idx,
           notequal, lessthan, sc_we, sc_o,
           lut_we, lut_waddr, lut_wdata,
    output pc, sc_in, running, done, instr_cnt
  );
endinterface

// File: rtl/pc_flag_unit.sv
// Program-flow stage after the ALU: PC with zero-penalty LUT branches, shift-carry
// flag, start/run/done control FSM and a saturating executed-instruction counter.
module pc_flag_unit #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  pc_flag_unit_if.slave bus
);

  localparam int LUT_N = 2 ** LUT_AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [PC_W-1:0] lut_t [LUT_N];

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             sc_q, sc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lut_t             lut_q, lut_d;

  logic [PC_W-1:0]  lut_rdata;
  logic             taken;
  logic [CNT_W-1:0] cnt_inc;

  // Read from the registered array, so a same-cycle write is only seen next cycle.
  assign lut_rdata = lut_q[bus.lut_idx];
  assign taken     = (bus.branch_ne & bus.notequal) | (bus.branch_lt & bus.lessthan);
  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch;
    // blocking '=' is correct here because this is combinational logic, not state.
    lut_d = lut_q;
    if (bus.lut_we) begin
      lut_d[bus.lut_waddr] = bus.lut_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sc_d    = sc_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        pc_d = '0;
        if (bus.start) begin
          state_d = ST_RUN;
          sc_d    = 1'b0;
          cnt_d   = '0;
        end
      end

      ST_RUN: begin
        cnt_d = cnt_inc;
        if (bus.halt_req) begin
          state_d = ST_DONE;
        end else begin
          pc_d = taken ? lut_rdata : pc_q + PC_W'(1);
          if (bus.sc_we) begin
            sc_d = bus.sc_o;
          end
        end
      end

      ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          sc_d    = 1'b0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
        sc_d    = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      sc_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sc_q    <= sc_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the target table must clear on reset, so it is built from resettable flops
  // rather than a RAM macro, which could not be cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LUT_N; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      lut_q <= lut_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.sc_in     = sc_q;
  assign bus.running   = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_pc_flag_unit.sv
// Scoreboard bench for pc_flag_unit: directed steps push expected state, a monitor
// pops one entry after every rising edge (or on demand for the async-reset check).
module tb_pc_flag_unit;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 4;
  localparam int CNT_W  = 4;   // narrow counter so saturation is reachable quickly

  typedef struct {
    string            name;
    logic [PC_W-1:0]  pc;
    logic             sc;
    logic             run;
    logic             dn;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_bad;
  exp_t sb_q[$];
  event check_now;

  pc_flag_unit_if #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)) bus ();

  pc_flag_unit #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor: compares the oldest expectation against the registered outputs.
  always begin
    @(posedge clk or check_now);
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_vec++;
      if (bus.pc !== e.pc || bus.sc_in !== e.sc || bus.running !== e.run ||
          bus.done !== e.dn || bus.instr_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s: got pc=%h sc=%b run=%b done=%b cnt=%0d, expected pc=%h sc=%b run=%b done=%b cnt=%0d",
                 e.name, bus.pc, bus.sc_in, bus.running, bus.done, bus.instr_cnt,
                 e.pc, e.sc, e.run, e.dn, e.cnt);
      end
    end
  end

  task automatic clear_in();
    bus.start     = 1'b0;
    bus.halt_req  = 1'b0;
    bus.branch_ne = 1'b0;
    bus.branch_lt = 1'b0;
    bus.lut_idx   = '0;
    bus.notequal  = 1'b0;
    bus.lessthan  = 1'b0;
    bus.sc_we     = 1'b0;
    bus.sc_o      = 1'b0;
    bus.lut_we    = 1'b0;
    bus.lut_waddr = '0;
    bus.lut_wdata = '0;
  endtask

  function automatic exp_t mk(string name, int pc, bit sc, bit run, bit dn, int cnt);
    exp_t e;
    e.name = name;
    e.pc   = PC_W'(pc);
    e.sc   = sc;
    e.run  = run;
    e.dn   = dn;
    e.cnt  = CNT_W'(cnt);
    return e;
  endfunction

  // Inputs are already driven; expectation describes outputs after the next rising edge.
  task automatic step(string name, int pc, bit sc, bit run, bit dn, int cnt);
    sb_q.push_back(mk(name, pc, sc, run, dn, cnt));
    @(negedge clk);
    clear_in();
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    clear_in();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    step("reset_idle", 0, 0, 0, 0, 0);
    bus.start = 1'b1;
    step("start", 0, 0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) step($sformatf("seq_%0d", i), i, 0, 1, 0, i);

    // Load LUT[3] while executing a plain instruction.
    bus.lut_we = 1'b1; bus.lut_waddr = 4'd3; bus.lut_wdata = 10'h120;
    step("lut_load", 6, 0, 1, 0, 6);
    bus.branch_ne = 1'b1; bus.lut_idx = 4'd3; bus.notequal = 1'b1;
    step("bne_taken", 'h120, 0, 1, 0, 7);
    bus.branch_ne = 1'b1; bus.lut_idx = 4'd3; bus.notequal = 1'b0;
    step("bne_not_taken", 'h121, 0, 1, 0, 8);

    bus.sc_we = 1'b1; bus.sc_o = 1'b1;
    step("sc_write", 'h122, 1, 1, 0, 9);
    bus.sc_we = 1'b0; bus.sc_o = 1'b0;
    step("sc_hold", 'h123, 1, 1, 0, 10);
    bus.branch_ne = 1'b1; bus.notequal = 1'b0; bus.branch_lt = 1'b1; bus.lessthan = 1'b1;
    bus.lut_idx = 4'd3;
    step("both_br_lt", 'h120, 1, 1, 0, 11);

    bus.halt_req = 1'b1; bus.branch_lt = 1'b1; bus.lessthan = 1'b1; bus.lut_idx = 4'd3;
    bus.sc_we = 1'b1; bus.sc_o = 1'b0;
    step("halt_over_br", 'h120, 1, 0, 1, 12);

    // Decode ignored in DONE; LUT write still accepted.
    bus.branch_ne = 1'b1; bus.notequal = 1'b1; bus.sc_we = 1'b1; bus.sc_o = 1'b0;
    bus.halt_req = 1'b1;
    bus.lut_we = 1'b1; bus.lut_waddr = 4'd5; bus.lut_wdata = 10'h3FF;
    step("done_hold", 'h120, 1, 0, 1, 12);
    bus.start = 1'b1;
    step("restart", 0, 0, 1, 0, 0);

    bus.branch_ne = 1'b1; bus.notequal = 1'b1; bus.lut_idx = 4'd5;
    step("br_to_3ff", 'h3FF, 0, 1, 0, 1);
    step("pc_wrap", 0, 0, 1, 0, 2);
    bus.lut_we = 1'b1; bus.lut_waddr = 4'd3; bus.lut_wdata = 10'h055;
    bus.branch_ne = 1'b1; bus.notequal = 1'b1; bus.lut_idx = 4'd3;
    step("wr_rd_old", 'h120, 0, 1, 0, 3);
    bus.branch_ne = 1'b1; bus.notequal = 1'b1; bus.lut_idx = 4'd3;
    step("wr_rd_new", 'h055, 0, 1, 0, 4);
    bus.start = 1'b1;
    step("start_in_run", 'h056, 0, 1, 0, 5);
    bus.sc_we = 1'b1; bus.sc_o = 1'b1;
    step("sc_set_pre_rst", 'h057, 1, 1, 0, 6);

    // Asynchronous reset between edges, checked before the next clock.
    #2;
    reset_n = 1'b0;
    sb_q.push_back(mk("async_reset", 0, 0, 0, 0, 0));
    -> check_now;
    @(negedge clk);
    reset_n = 1'b1;

    bus.start = 1'b1;
    step("start_post_rst", 0, 0, 1, 0, 0);
    bus.branch_ne = 1'b1; bus.notequal = 1'b1; bus.lut_idx = 4'd3;
    step("lut_cleared", 0, 0, 1, 0, 1);
    for (int k = 2; k <= 18; k++) begin
      step($sformatf("sat_%0d", k), k - 1, 0, 1, 0, (k > 15) ? 15 : k);
    end

    @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
